mult_div_unit: RTL and testbench
================================

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state changes on posedge clk.
REQ-002 SHALL have port: rst  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-003 SHALL have port: start  input  1  request to begin the operation selected by op.
REQ-004 SHALL have port: op  input  2  operation: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
REQ-005 SHALL have port: operandA  input  32  rs value, taken from register-file readData1.
REQ-006 SHALL have port: operandB  input  32  rt value, taken from register-file readData2.
REQ-007 SHALL have port: hiWe  input  1  MTHI write strobe.
REQ-008 SHALL have port: loWe  input  1  MTLO write strobe.
REQ-009 SHALL have port: moveData  input  32  data for MTHI/MTLO.
REQ-010 SHALL have port: busy  output  1  operation in progress.
REQ-011 SHALL have port: done  output  1  one-cycle completion pulse.
REQ-012 SHALL have port: divByZero  output  1  sticky flag: last completed divide had operandB == 0.
REQ-013 SHALL have port: hi  output  32  HI register (product upper word / remainder).
REQ-014 SHALL have port: lo  output  32  LO register (product lower word / quotient).

Function
REQ-015 SHALL use FSM states IDLE and RUN, plus a 6-bit iteration counter.
REQ-016 SHALL, in IDLE with start=1 at edge E0, latch op, operandA and operandB, enter RUN, and assert busy from E0 onward.
REQ-017 SHALL ignore start while busy=1; latched operands and op are unaffected by input changes during RUN.
REQ-018 SHALL perform exactly one iteration per cycle at edges E1..E32: shift-add for multiply, restoring shift-subtract for divide.
REQ-019 SHALL, at E32, write hi and lo, return to IDLE, deassert busy, and assert done for exactly one cycle.
REQ-020 SHALL keep hi and lo unchanged from E0 to E32; they hold the previous result until E32.
REQ-021 SHALL, for signed ops, operate on operand magnitudes and apply signs at completion: 64-bit product sign = signA XOR signB; quotient sign = signA XOR signB; remainder sign = signA.
REQ-022 SHALL produce, for MULT/MULTU, the full 64-bit product: {hi,lo}.
REQ-023 SHALL produce, for DIV/DIVU, lo = quotient and hi = remainder.
REQ-024 SHALL, for DIV 0x80000000 / 0xFFFFFFFF, produce lo=0x80000000 and hi=0x00000000 (quotient truncated to 32 bits).
REQ-025 SHALL, on divide with operandB=0, still take 32 cycles, then set lo=0xFFFFFFFF, hi=operandA and divByZero=1.
REQ-026 SHALL clear divByZero on completion of any later multiply, and of any later divide whose operandB is nonzero.
REQ-027 SHALL, in IDLE with start=0, write moveData to hi on hiWe and to lo on loWe at the next edge; both strobes may be active in the same cycle.
REQ-028 SHALL ignore hiWe and loWe while busy=1, and in a cycle where start is accepted (start has priority).
REQ-029 SHALL accept start in the same cycle that done=1, since busy=0 in that cycle; busy then stays low for that cycle only.

Reset
REQ-030 SHALL, when rst=1 at a clock edge, set the FSM to IDLE, the counter to 0, busy=0, done=0, divByZero=0, hi=0 and lo=0, regardless of other inputs.
REQ-031 SHALL, when rst is asserted mid-RUN, abort the operation; no done pulse occurs and no partial result appears on hi or lo.
REQ-032 SHALL ignore start, hiWe and loWe in any cycle where rst=1.

Verification
REQ-033 Bench SHALL cover: MULT 0xFFFFFFFE (-2) x 0x00000003 -> after 32 cycles hi=0xFFFFFFFF, lo=0xFFFFFFFA, with a single done pulse.
REQ-034 Bench SHALL cover: MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-035 Bench SHALL cover: DIV 0xFFFFFFF9 (-7) / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 7 / 2 -> lo=3, hi=1.
REQ-036 Bench SHALL cover: DIVU 5 / 0 -> lo=0xFFFFFFFF, hi=5, divByZero=1; a following MULTU 2x3 -> lo=6, hi=0, divByZero=0.
REQ-037 Bench SHALL cover: start a new op at cycle 10 of RUN, with hiWe=1 -> ignored; first result unchanged; hi not overwritten.
REQ-038 Bench SHALL cover: rst at cycle 16 of RUN -> next cycle busy=0, hi=lo=0, no done pulse; a fresh MULTU 4x5 then yields lo=20.

Source files
------------

// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : mult_div_unit
// Description : Iterative 32x32 multiply / 32/32 divide unit with HI/LO
//               result registers. One iteration per clock over 32 cycles:
//               shift-add for multiply, restoring shift-subtract for divide.
//               Signed ops run on magnitudes; signs are fixed up at the end.
// Revision    : 1.0 - initial release
// ============================================================================
module mult_div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] operandA,
    input  logic [31:0] operandB,
    input  logic        hiWe,
    input  logic        loWe,
    input  logic [31:0] moveData,
    output logic        busy,
    output logic        done,
    output logic        divByZero,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [0:0] c_S_IDLE   = 1'b0;
    localparam logic [0:0] c_S_RUN    = 1'b1;
    localparam logic [5:0] c_LAST_ITR = 6'd31;

    logic [0:0]  r_state;
    logic [5:0]  r_cnt;
    logic        r_busy;
    logic        r_done;
    logic        r_dbz;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_is_div;
    logic        r_neg_res;   // sign of product / quotient
    logic        r_neg_a;     // sign of remainder
    logic        r_b_zero;
    logic [31:0] r_a_raw;     // original dividend, reported on divide-by-zero
    logic [31:0] r_opnd;      // multiplicand magnitude or divisor magnitude
    logic [63:0] r_p;         // mult: {partial sum, multiplier}; div: {rem, quo}

    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [32:0] w_mul_sum;
    logic [63:0] w_mul_next;
    logic [32:0] w_rem_sh;
    logic [32:0] w_diff;
    logic [63:0] w_div_next;
    logic [63:0] w_next;
    logic [63:0] w_prod_fix;
    logic [31:0] w_quo_fix;
    logic [31:0] w_rem_fix;

    // Operand magnitudes for the op being requested (op[0]=0 means signed)
    always_comb begin
        w_a_neg = ~op[0] & operandA[31];
        w_b_neg = ~op[0] & operandB[31];
        w_a_mag = w_a_neg ? (32'd0 - operandA) : operandA;
        w_b_mag = w_b_neg ? (32'd0 - operandB) : operandB;
    end

    // One iteration of each algorithm plus the final sign correction
    always_comb begin
        // Multiply: add multiplicand when the multiplier LSB is set, shift right
        w_mul_sum  = {1'b0, r_p[63:32]} + (r_p[0] ? {1'b0, r_opnd} : 33'd0);
        w_mul_next = {w_mul_sum, r_p[31:1]};
        // Divide: shift next dividend bit into the remainder, try subtraction
        w_rem_sh   = {r_p[63:32], r_p[31]};
        w_diff     = w_rem_sh - {1'b0, r_opnd};
        w_div_next = w_diff[32] ? {w_rem_sh[31:0], r_p[30:0], 1'b0}
                                : {w_diff[31:0],   r_p[30:0], 1'b1};
        w_next     = r_is_div ? w_div_next : w_mul_next;
        w_prod_fix = r_neg_res ? (64'd0 - w_next) : w_next;
        w_quo_fix  = r_neg_res ? (32'd0 - w_next[31:0]) : w_next[31:0];
        w_rem_fix  = r_neg_a ? (32'd0 - w_next[63:32]) : w_next[63:32];
    end

    // Control FSM, iteration datapath and HI/LO result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_S_IDLE;
            r_cnt     <= 6'd0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_dbz     <= 1'b0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
            r_is_div  <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_a   <= 1'b0;
            r_b_zero  <= 1'b0;
            r_a_raw   <= 32'd0;
            r_opnd    <= 32'd0;
            r_p       <= 64'd0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_S_IDLE: begin
                    if (start) begin
                        r_state   <= c_S_RUN;
                        r_busy    <= 1'b1;
                        r_cnt     <= 6'd0;
                        r_is_div  <= op[1];
                        r_neg_res <= w_a_neg ^ w_b_neg;
                        r_neg_a   <= w_a_neg;
                        r_b_zero  <= (operandB == 32'd0);
                        r_a_raw   <= operandA;
                        r_opnd    <= op[1] ? w_b_mag : w_a_mag;
                        r_p       <= op[1] ? {32'd0, w_a_mag} : {32'd0, w_b_mag};
                    end else begin
                        if (hiWe) r_hi <= moveData;
                        if (loWe) r_lo <= moveData;
                    end
                end
                c_S_RUN: begin
                    r_p   <= w_next;
                    r_cnt <= r_cnt + 6'd1;
                    if (r_cnt == c_LAST_ITR) begin
                        r_state <= c_S_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_cnt   <= 6'd0;
                        if (r_is_div) begin
                            if (r_b_zero) begin
                                r_hi  <= r_a_raw;
                                r_lo  <= 32'hFFFF_FFFF;
                                r_dbz <= 1'b1;
                            end else begin
                                r_hi  <= w_rem_fix;
                                r_lo  <= w_quo_fix;
                                r_dbz <= 1'b0;
                            end
                        end else begin
                            r_hi  <= w_prod_fix[63:32];
                            r_lo  <= w_prod_fix[31:0];
                            r_dbz <= 1'b0;
                        end
                    end
                end
                default: r_state <= c_S_IDLE;
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign divByZero = r_dbz;
    assign hi        = r_hi;
    assign lo        = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mult_div_unit
// Description : Self-checking bench for mult_div_unit. Directed corner cases
//               plus randomized ops compared against a plain-arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] operandA = 32'd0;
    logic [31:0] operandB = 32'd0;
    logic        hiWe = 1'b0;
    logic        loWe = 1'b0;
    logic [31:0] moveData = 32'd0;
    logic        busy;
    logic        done;
    logic        divByZero;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks = 0;
    int n_err    = 0;

    mult_div_unit dut (
        .clk(clk), .rst(rst), .start(start), .op(op),
        .operandA(operandA), .operandB(operandB),
        .hiWe(hiWe), .loWe(loWe), .moveData(moveData),
        .busy(busy), .done(done), .divByZero(divByZero),
        .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    // Reference model: returns {divByZero, hi, lo}
    function automatic logic [64:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = $signed(a);
        sb = $signed(b);
        case (o)
            2'b00: begin p = sa * sb; return {1'b0, p}; end
            2'b01: begin p = {32'd0, a} * {32'd0, b}; return {1'b0, p}; end
            2'b10: begin
                if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {1'b0, r[31:0], q[31:0]};
            end
            default: begin
                if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
                return {1'b0, a % b, a / b};
            end
        endcase
    endfunction

    // Issue one op from IDLE and wait (bounded) for its done pulse
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output logic [31:0] rhi, output logic [31:0] rlo,
                          output logic rdbz, output bit hold_ok, output bit pulse_ok);
        logic [31:0] h0, l0;
        @(negedge clk);
        h0 = hi; l0 = lo;
        start = 1'b1; op = o; operandA = a; operandB = b;
        @(negedge clk);
        start = 1'b0; op = 2'($urandom); operandA = $urandom; operandB = $urandom;
        hold_ok = 1'b1;
        lat = -1;
        for (int k = 0; k < 40; k++) begin
            if (done) begin lat = k; break; end
            if (hi !== h0 || lo !== l0 || busy !== 1'b1) hold_ok = 1'b0;
            @(negedge clk);
        end
        rhi = hi; rlo = lo; rdbz = divByZero;
        pulse_ok = (busy === 1'b0);
        @(negedge clk);
        pulse_ok = pulse_ok && (done === 1'b0);
    endtask

    task automatic test_reset();
        // Reset held with start/strobes active: everything must stay cleared
        start = 1'b1; hiWe = 1'b1; loWe = 1'b1; moveData = 32'hA5A5_5A5A;
        operandA = 32'd7; operandB = 32'd3;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({busy, done, divByZero} !== 3'b000 || hi !== 32'd0 || lo !== 32'd0) begin
            n_err++;
            $display("FAIL reset: busy/done/dbz=%b hi=%h lo=%h required 000 0 0", {busy, done, divByZero}, hi, lo);
        end
        rst = 1'b0; start = 1'b0; hiWe = 1'b0; loWe = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            n_err++;
            $display("FAIL reset_release: busy=%b hi=%h lo=%h required 0 0 0", busy, hi, lo);
        end
    endtask

    task automatic test_directed();
        logic [1:0]  t_op [6] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b11, 2'b01};
        logic [31:0] t_a  [6] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'd7, 32'd5, 32'd2};
        logic [31:0] t_b  [6] = '{32'd3, 32'hFFFF_FFFF, 32'd2, 32'd2, 32'd0, 32'd3};
        logic [31:0] t_hi [6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd1, 32'd5, 32'd0};
        logic [31:0] t_lo [6] = '{32'hFFFF_FFFA, 32'h0000_0001, 32'hFFFF_FFFD, 32'd3, 32'hFFFF_FFFF, 32'd6};
        logic        t_dz [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        int lat; logic [31:0] rh, rl; logic rd; bit hok, pok;
        for (int i = 0; i < 6; i++) begin
            run_op(t_op[i], t_a[i], t_b[i], lat, rh, rl, rd, hok, pok);
            n_checks++;
            if (rh !== t_hi[i] || rl !== t_lo[i] || rd !== t_dz[i]) begin
                n_err++;
                $display("FAIL directed[%0d]: hi=%h lo=%h dbz=%b required hi=%h lo=%h dbz=%b",
                         i, rh, rl, rd, t_hi[i], t_lo[i], t_dz[i]);
            end
            n_checks++;
            if (lat != 32 || !hok || !pok) begin
                n_err++;
                $display("FAIL directed_timing[%0d]: latency=%0d hold=%0d single_pulse=%0d required 32 1 1",
                         i, lat, hok, pok);
            end
        end
    endtask

    task automatic test_div_overflow();
        int lat; logic [31:0] rh, rl; logic rd; bit hok, pok;
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, lat, rh, rl, rd, hok, pok);
        n_checks++;
        if (rh !== 32'd0 || rl !== 32'h8000_0000 || lat != 32) begin
            n_err++;
            $display("FAIL div_overflow: hi=%h lo=%h lat=%0d required 0 80000000 32", rh, rl, lat);
        end
    endtask

    task automatic test_random();
        int lat; logic [31:0] rh, rl, a, b; logic rd; bit hok, pok;
        logic [1:0] o; logic [64:0] exp;
        for (int i = 0; i < 40; i++) begin
            o = 2'($urandom_range(0, 3));
            a = $urandom; b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: a = 32'h8000_0000;
                2: b = 32'hFFFF_FFFF;
                3: b = 32'($urandom_range(1, 15));
                default: ;
            endcase
            exp = model(o, a, b);
            run_op(o, a, b, lat, rh, rl, rd, hok, pok);
            n_checks++;
            if ({rd, rh, rl} !== exp || lat != 32 || !hok || !pok) begin
                n_err++;
                $display("FAIL random[%0d] op=%0d a=%h b=%h: dbz/hi/lo=%h lat=%0d hold=%0d pulse=%0d required %h 32 1 1",
                         i, o, a, b, {rd, rh, rl}, lat, hok, pok, exp);
            end
        end
    endtask

    task automatic test_move();
        logic [31:0] l_prev;
        bit seen;
        @(negedge clk);
        l_prev = lo;
        hiWe = 1'b1; moveData = 32'h1111_2222;
        @(negedge clk); hiWe = 1'b0;
        n_checks++;
        if (hi !== 32'h1111_2222 || lo !== l_prev) begin
            n_err++;
            $display("FAIL mthi: hi=%h lo=%h required 11112222 %h", hi, lo, l_prev);
        end
        loWe = 1'b1; moveData = 32'h3333_4444;
        @(negedge clk); loWe = 1'b0;
        n_checks++;
        if (hi !== 32'h1111_2222 || lo !== 32'h3333_4444) begin
            n_err++;
            $display("FAIL mtlo: hi=%h lo=%h required 11112222 33334444", hi, lo);
        end
        hiWe = 1'b1; loWe = 1'b1; moveData = 32'h5555_6666;
        @(negedge clk); hiWe = 1'b0; loWe = 1'b0;
        n_checks++;
        if (hi !== 32'h5555_6666 || lo !== 32'h5555_6666) begin
            n_err++;
            $display("FAIL mthi_mtlo: hi=%h lo=%h required 55556666 55556666", hi, lo);
        end
        // start has priority over the move strobes
        start = 1'b1; op = 2'b01; operandA = 32'd3; operandB = 32'd3;
        hiWe = 1'b1; loWe = 1'b1; moveData = 32'h7777_8888;
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (hi !== 32'h5555_6666 || lo !== 32'h5555_6666 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL start_priority: hi=%h lo=%h busy=%b required 55556666 55556666 1", hi, lo, busy);
        end
        // strobes still high while busy: must be ignored
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        hiWe = 1'b0; loWe = 1'b0;
        n_checks++;
        if (!seen || hi !== 32'd0 || lo !== 32'd9) begin
            n_err++;
            $display("FAIL move_ignored_busy: done_seen=%0d hi=%h lo=%h required 1 0 9", seen, hi, lo);
        end
        // reset wins over strobes and start
        rst = 1'b1; start = 1'b1; hiWe = 1'b1; loWe = 1'b1; moveData = 32'hCAFE_F00D;
        @(negedge clk);
        rst = 1'b0; start = 1'b0; hiWe = 1'b0; loWe = 1'b0;
        @(negedge clk);
        n_checks++;
        if (hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_over_strobes: hi=%h lo=%h busy=%b required 0 0 0", hi, lo, busy);
        end
    endtask

    task automatic test_ignore_during_run();
        logic [31:0] a, b; logic [64:0] exp; int lat;
        a = 32'h1234_5678; b = 32'h9ABC_DEF0;
        exp = model(2'b01, a, b);
        @(negedge clk);
        start = 1'b1; op = 2'b01; operandA = a; operandB = b;
        @(negedge clk);
        start = 1'b0;
        lat = -1;
        for (int k = 0; k < 40; k++) begin
            if (done) begin lat = k; break; end
            if (k == 10) begin
                start = 1'b1; op = 2'b10; operandA = 32'd100; operandB = 32'd7;
                hiWe = 1'b1; moveData = 32'hDEAD_BEEF;
            end else if (k == 11) begin
                start = 1'b0; hiWe = 1'b0;
            end
            @(negedge clk);
        end
        n_checks++;
        if ({divByZero, hi, lo} !== exp || lat != 32) begin
            n_err++;
            $display("FAIL ignore_during_run: dbz/hi/lo=%h lat=%0d required %h 32", {divByZero, hi, lo}, lat, exp);
        end
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== exp[63:32]) begin
            n_err++;
            $display("FAIL ignore_no_second_op: busy=%b done=%b hi=%h required 0 0 %h", busy, done, hi, exp[63:32]);
        end
    endtask

    task automatic test_reset_mid_run();
        int lat; logic [31:0] rh, rl; logic rd; bit hok, pok, seen;
        // leave divByZero set so its clearing by reset is visible
        run_op(2'b11, 32'd9, 32'd0, lat, rh, rl, rd, hok, pok);
        @(negedge clk);
        start = 1'b1; op = 2'b01; operandA = $urandom; operandB = $urandom;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 16; k++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || divByZero !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            n_err++;
            $display("FAIL reset_mid_run: busy=%b done=%b dbz=%b hi=%h lo=%h required 0 0 0 0 0",
                     busy, done, divByZero, hi, lo);
        end
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done || busy || hi !== 32'd0 || lo !== 32'd0) seen = 1'b1;
        end
        n_checks++;
        if (seen) begin
            n_err++;
            $display("FAIL reset_abort_quiet: activity_seen=%0d required 0", seen);
        end
        run_op(2'b01, 32'd4, 32'd5, lat, rh, rl, rd, hok, pok);
        n_checks++;
        if (rl !== 32'd20 || rh !== 32'd0 || lat != 32) begin
            n_err++;
            $display("FAIL after_reset_op: hi=%h lo=%h lat=%0d required 0 14 32", rh, rl, lat);
        end
    endtask

    task automatic test_back_to_back();
        logic [64:0] exp1, exp2; int lat;
        exp1 = model(2'b00, 32'hFFFF_F000, 32'h0000_1234);
        exp2 = model(2'b10, 32'h7FFF_FFFF, 32'hFFFF_FFFD);
        @(negedge clk);
        start = 1'b1; op = 2'b00; operandA = 32'hFFFF_F000; operandB = 32'h0000_1234;
        @(negedge clk);
        start = 1'b0;
        lat = -1;
        for (int k = 0; k < 40; k++) begin
            if (done) begin lat = k; break; end
            @(negedge clk);
        end
        n_checks++;
        if ({divByZero, hi, lo} !== exp1 || busy !== 1'b0 || lat != 32) begin
            n_err++;
            $display("FAIL b2b_first: dbz/hi/lo=%h busy=%b lat=%0d required %h 0 32", {divByZero, hi, lo}, busy, lat, exp1);
        end
        // start issued in the done cycle
        start = 1'b1; op = 2'b10; operandA = 32'h7FFF_FFFF; operandB = 32'hFFFF_FFFD;
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_accept: busy=%b done=%b required 1 0", busy, done);
        end
        lat = -1;
        for (int k = 0; k < 40; k++) begin
            if (done) begin lat = k; break; end
            @(negedge clk);
        end
        n_checks++;
        if ({divByZero, hi, lo} !== exp2 || lat != 32) begin
            n_err++;
            $display("FAIL b2b_second: dbz/hi/lo=%h lat=%0d required %h 32", {divByZero, hi, lo}, lat, exp2);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_div_overflow();
        test_random();
        test_move();
        test_ignore_during_run();
        test_reset_mid_run();
        test_back_to_back();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
